// File: rtl/core_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// core_bus_arbiter_if
//   Bundles every signal between the two cores, the shared memory port and the
//   snoop bus around core_bus_arbiter.
//   modport master : arbiter view (takes core requests and memory responses,
//                    drives completions, the memory request and the snoop bus)
//   modport slave  : environment view (cores + memory + snoop listeners)
//   Per-core:  req_x, we_x, addr_x, wdata_x  -> arbiter
//              done_x, rdata_x, err_x        <- arbiter
//   Memory:    mem_req, mem_we, mem_addr, mem_wdata <- arbiter
//              mem_rdata, mem_ready                 -> arbiter
//   Snoop:     snoop_valid, snoop_src, snoop_we, snoop_addr <- arbiter
// ----------------------------------------------------------------------------
interface core_bus_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              done_a;
    logic              done_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              err_a;
    logic              err_b;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              snoop_valid;
    logic              snoop_src;
    logic              snoop_we;
    logic [ADDR_W-1:0] snoop_addr;

    modport master (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  mem_rdata, mem_ready,
        output done_a, done_b, rdata_a, rdata_b, err_a, err_b,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output snoop_valid, snoop_src, snoop_we, snoop_addr
    );

    modport slave (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output mem_rdata, mem_ready,
        input  done_a, done_b, rdata_a, rdata_b, err_a, err_b,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  snoop_valid, snoop_src, snoop_we, snoop_addr
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// ----------------------------------------------------------------------------
// core_bus_arbiter
//   Round-robin arbiter sharing one memory port between cores A and B.
//   Each granted transaction is latched, broadcast on the snoop bus for one
//   cycle, run on the memory handshake, then completed back to its core.
//   FSM: IDLE -> SNOOP -> MEM -> DONE -> IDLE, one transaction in flight.
//   Ports:
//     clk   : single clock, rising edge
//     reset : asynchronous, active-high; clears state and every output
//     bus   : core_bus_arbiter_if.master (core requests/completions,
//             memory handshake, snoop broadcast)
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   -> MEM aborts after TIMEOUT_CYCLES cycles without mem_ready,
//                  completing with done_x and err_x together
//     undefined -> MEM waits indefinitely, err_a/err_b tied to 0
// ----------------------------------------------------------------------------
module core_bus_arbiter #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               reset,
    core_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        MEM   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              last_grant;   // 0 = A, 1 = B
    logic              bus_src;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;
    logic              grant_b;
    logic              any_req;
    logic              mem_abort;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("core_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    assign any_req = bus.req_a | bus.req_b;
    // On a tie the core that did not win last time gets the bus.
    assign grant_b = bus.req_b & (~bus.req_a | ~last_grant);

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Abort on the MEM cycle that would bring the wait count up to the limit;
    // a mem_ready in that same cycle takes priority.
    assign mem_abort = (state == MEM) && !bus.mem_ready &&
                       (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != MEM)
                tmo_cnt <= '0;
            else if (!bus.mem_ready)
                tmo_cnt <= tmo_cnt + 8'd1;
            err_q <= mem_abort;
        end
    end

    assign bus.err_a = err_q & ~bus_src;
    assign bus.err_b = err_q &  bus_src;
`else
    assign mem_abort = 1'b0;
    assign bus.err_a = 1'b0;
    assign bus.err_b = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus the handshake outputs decoded from the state register.
    always_comb begin
        state_nxt       = state;
        bus.snoop_valid = 1'b0;
        bus.mem_req     = 1'b0;
        bus.done_a      = 1'b0;
        bus.done_b      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = SNOOP;
            end
            SNOOP: begin
                bus.snoop_valid = 1'b1;
                state_nxt       = MEM;
            end
            MEM: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready || mem_abort)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.done_a = ~bus_src;
                bus.done_b =  bus_src;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            bus_src    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                bus_src   <= grant_b;
                bus_we    <= grant_b ? bus.we_b    : bus.we_a;
                bus_addr  <= grant_b ? bus.addr_b  : bus.addr_a;
                bus_wdata <= grant_b ? bus.wdata_b : bus.wdata_a;
            end
            // Read data lands in the core's register on the edge entering
            // DONE, so it is visible together with the done pulse.
            if (state == MEM && bus.mem_ready && !bus_we) begin
                if (bus_src)
                    rdata_b_q <= bus.mem_rdata;
                else
                    rdata_a_q <= bus.mem_rdata;
            end
            if (state == DONE)
                last_grant <= bus_src;
        end
    end

    assign bus.rdata_a    = rdata_a_q;
    assign bus.rdata_b    = rdata_b_q;
    assign bus.mem_we     = bus_we;
    assign bus.mem_addr   = bus_addr;
    assign bus.mem_wdata  = bus_wdata;
    assign bus.snoop_src  = bus_src;
    assign bus.snoop_we   = bus_we;
    assign bus.snoop_addr = bus_addr;

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
`ifdef BUS_TIMEOUT_EN
    localparam int STALL = 10;
`else
    localparam int STALL = 40;
`endif

    logic clk;
    logic reset;

    core_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    core_bus_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic        we;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    typedef struct {
        logic        ra;
        logic        rb;
        logic        wa;
        logic        wb;
        logic [8:0]  aa;
        logic [8:0]  ab;
        logic [15:0] da;
        logic [15:0] db;
        logic [15:0] rda;
        logic [15:0] rdb;
        logic        first_b;
        int          dly;
    } vec_t;

    txn_t        sbq[$];
    vec_t        vt[6];
    int          checks;
    int          failures;
    logic [15:0] exp_rd_a;
    logic [15:0] exp_rd_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic src, input logic we, input logic [8:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata);
        txn_t t;
        t.src = src; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    // Drives the memory side and checks snoop/memory/completion outputs against
    // the scoreboard until n completions have been seen.
    task automatic run_txns(input int n, input bit hold, input int dly, input int exp_lat);
        int   seen;
        int   cyc;
        int   mem_cnt;
        int   snoop_cnt;
        txn_t t;
        seen = 0; cyc = 0; mem_cnt = 0; snoop_cnt = 0;
        while (seen < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.snoop_valid) begin
                snoop_cnt++;
                if (sbq.size() > 0) begin
                    chk("snoop_src", bus.snoop_src, sbq[0].src);
                    chk("snoop_we", bus.snoop_we, sbq[0].we);
                    chk("snoop_addr", bus.snoop_addr, sbq[0].addr);
                end
            end
            if (bus.mem_req) begin
                mem_cnt++;
                if (sbq.size() > 0) begin
                    chk("mem_we", bus.mem_we, sbq[0].we);
                    chk("mem_addr", bus.mem_addr, sbq[0].addr);
                    chk("mem_wdata", bus.mem_wdata, sbq[0].wdata);
                    bus.mem_rdata = sbq[0].rdata;
                end
                bus.mem_ready = (mem_cnt > dly);
            end else begin
                mem_cnt = 0;
                bus.mem_ready = (dly == 0);
            end
            if (bus.done_a || bus.done_b) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    t = sbq.pop_front();
                    chk("done_src", {bus.done_b, bus.done_a}, t.src ? 2'b10 : 2'b01);
                    if (!t.we) begin
                        if (t.src) exp_rd_b = t.rdata;
                        else       exp_rd_a = t.rdata;
                    end
                    chk("rdata_a", bus.rdata_a, exp_rd_a);
                    chk("rdata_b", bus.rdata_b, exp_rd_b);
                    chk("err", {bus.err_b, bus.err_a}, 2'b00);
                    chk("snoop_once", snoop_cnt, 1);
                    if (seen == 0 && exp_lat > 0)
                        chk("latency", cyc, exp_lat);
                    snoop_cnt = 0;
                    seen++;
                    if (!hold) begin
                        if (t.src) bus.req_b = 1'b0;
                        else       bus.req_a = 1'b0;
                    end else if (seen == n) begin
                        bus.req_a = 1'b0;
                        bus.req_b = 1'b0;
                    end
                end
            end
        end
        if (seen < n)
            chk("txn_timeout", seen, n);
    endtask

    initial begin
        int  cyc;
        int  mcnt;
        bit  got;
        checks = 0; failures = 0;
        exp_rd_a = '0; exp_rd_b = '0;
        reset = 1'b1;
        bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
        bus.addr_a = '0; bus.addr_b = '0; bus.wdata_a = '0; bus.wdata_b = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;

        //            ra rb wa wb  aa      ab      da        db        rda       rdb       1stB dly
        vt[0] = '{1, 1, 1, 1, 9'h010, 9'h011, 16'hBEEF, 16'hCAFE, 16'h0BAD, 16'h0BAD, 0, 0};
        vt[1] = '{1, 0, 0, 0, 9'h005, 9'h000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0, 0};
        vt[2] = '{0, 1, 0, 0, 9'h000, 9'h0A0, 16'h0000, 16'h1111, 16'h0000, 16'h5A5A, 1, 2};
        vt[3] = '{1, 1, 0, 0, 9'h1FF, 9'h000, 16'h2222, 16'h3333, 16'hFFFF, 16'h0001, 0, 0};
        vt[4] = '{1, 0, 1, 0, 9'h155, 9'h000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 0, 5};
        vt[5] = '{0, 1, 0, 1, 9'h000, 9'h044, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_snoop_valid", bus.snoop_valid, 0);
        chk("rst_done", {bus.done_b, bus.done_a}, 0);
        chk("rst_rdata", {bus.rdata_b, bus.rdata_a}, 0);
        chk("rst_snoop_bus", {bus.snoop_src, bus.snoop_we, bus.snoop_addr}, 0);
        chk("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_a = vt[i].ra; bus.req_b = vt[i].rb;
            bus.we_a = vt[i].wa; bus.we_b = vt[i].wb;
            bus.addr_a = vt[i].aa; bus.addr_b = vt[i].ab;
            bus.wdata_a = vt[i].da; bus.wdata_b = vt[i].db;
            if (vt[i].ra && vt[i].rb) begin
                if (vt[i].first_b) begin
                    sbq.push_back(mk(1, vt[i].wb, vt[i].ab, vt[i].db, vt[i].rdb));
                    sbq.push_back(mk(0, vt[i].wa, vt[i].aa, vt[i].da, vt[i].rda));
                end else begin
                    sbq.push_back(mk(0, vt[i].wa, vt[i].aa, vt[i].da, vt[i].rda));
                    sbq.push_back(mk(1, vt[i].wb, vt[i].ab, vt[i].db, vt[i].rdb));
                end
                run_txns(2, 0, vt[i].dly, 3 + vt[i].dly);
            end else if (vt[i].ra) begin
                sbq.push_back(mk(0, vt[i].wa, vt[i].aa, vt[i].da, vt[i].rda));
                run_txns(1, 0, vt[i].dly, 3 + vt[i].dly);
            end else begin
                sbq.push_back(mk(1, vt[i].wb, vt[i].ab, vt[i].db, vt[i].rdb));
                run_txns(1, 0, vt[i].dly, 3 + vt[i].dly);
            end
        end

        // Continuous contention: grants alternate A,B,A,B.
        @(negedge clk);
        bus.req_a = 1; bus.req_b = 1; bus.we_a = 0; bus.we_b = 0;
        bus.addr_a = 9'h100; bus.addr_b = 9'h101;
        bus.wdata_a = 16'h0000; bus.wdata_b = 16'h0000;
        sbq.push_back(mk(0, 0, 9'h100, 16'h0000, 16'h1111));
        sbq.push_back(mk(1, 0, 9'h101, 16'h0000, 16'h2222));
        sbq.push_back(mk(0, 0, 9'h100, 16'h0000, 16'h3333));
        sbq.push_back(mk(1, 0, 9'h101, 16'h0000, 16'h4444));
        run_txns(4, 1, 0, 3);

        // mem_ready arriving on the 15th MEM cycle completes normally.
        @(negedge clk);
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 9'h077; bus.wdata_a = 16'h0000;
        sbq.push_back(mk(0, 0, 9'h077, 16'h0000, 16'h9999));
        run_txns(1, 0, 14, 17);

`ifdef BUS_TIMEOUT_EN
        // Memory never answers: B read aborts after 15 MEM cycles.
        @(negedge clk);
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 9'h0AB; bus.wdata_b = 16'h0000;
        bus.mem_ready = 0; bus.mem_rdata = 16'hDEAD;
        mcnt = 0; cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_req) mcnt++;
            if (bus.done_a || bus.done_b) begin
                got = 1;
                chk("tmo_done", {bus.done_b, bus.done_a}, 2'b10);
                chk("tmo_err", {bus.err_b, bus.err_a}, 2'b10);
                chk("tmo_rdata_b", bus.rdata_b, exp_rd_b);
                chk("tmo_mem_cycles", mcnt, 15);
                chk("tmo_mem_req_low", bus.mem_req, 0);
            end
        end
        if (!got) chk("tmo_no_done", 0, 1);
        bus.req_b = 0;
        @(negedge clk);
        chk("tmo_idle", {bus.mem_req, bus.snoop_valid, bus.done_b, bus.err_b}, 0);
        // Ensure A was the most recent grant before the reset check below.
        @(negedge clk);
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 9'h0EE; bus.wdata_a = 16'h4321;
        sbq.push_back(mk(0, 1, 9'h0EE, 16'h4321, 16'h0000));
        run_txns(1, 0, 0, 3);
`endif

        // Stall B in MEM, then reset mid-transaction.
        @(negedge clk);
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 9'h0CD; bus.wdata_b = 16'h0000;
        bus.mem_ready = 0;
        cyc = 0;
        while (!bus.mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        repeat (STALL) @(negedge clk);
        chk("stall_mem_req", bus.mem_req, 1);
        chk("stall_mem_addr", bus.mem_addr, 9'h0CD);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", bus.mem_req, 0);
        chk("mid_rst_snoop", bus.snoop_valid, 0);
        chk("mid_rst_done_err", {bus.done_b, bus.done_a, bus.err_b, bus.err_a}, 0);
        chk("mid_rst_rdata_a", bus.rdata_a, 0);
        chk("mid_rst_rdata_b", bus.rdata_b, 0);
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        bus.req_b = 0;
        exp_rd_a = '0; exp_rd_b = '0;
        @(negedge clk);
        reset = 1'b0;

        // First tie after reset goes to A.
        @(negedge clk);
        bus.req_a = 1; bus.req_b = 1; bus.we_a = 0; bus.we_b = 0;
        bus.addr_a = 9'h020; bus.addr_b = 9'h021;
        bus.wdata_a = 16'h0000; bus.wdata_b = 16'h0000;
        sbq.push_back(mk(0, 0, 9'h020, 16'h0000, 16'hA0A0));
        sbq.push_back(mk(1, 0, 9'h021, 16'h0000, 16'hB0B0));
        run_txns(2, 0, 0, 3);

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
